// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// FSM state encoding.
package shift_pkg;

    // Operation select values on the mode port
    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Controller states; busy is simply "state is ST_SHIFT"
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift/rotate step. Purely combinational: given the current
// register value, the operation and the serial fill bit, produce the value
// after one step and the bit that leaves the register.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    // up_hi holds q moved one place toward the MSB (bits WIDTH-1..1),
    // dn_lo holds q moved one place toward the LSB (bits WIDTH-2..0).
    // The vacated end is filled per operation below.
    logic [WIDTH-1:1] up_hi;
    logic [WIDTH-2:0] dn_lo;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_move
            assign up_hi[gi+1] = q[gi];
            assign dn_lo[gi]   = q[gi+1];
        end
    endgenerate

    // Select fill bit and exiting bit for the requested operation
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next  = {up_hi, sin};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {sin, dn_lo};
                out_bit = q[0];
            end
            MODE_ROL: begin
                q_next  = {up_hi, q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], dn_lo};
                out_bit = q[0];
            end
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus a self-timed run of `amount`
// single-bit shift/rotate steps (one per clock) ending in a one-cycle done.
// A load during a run aborts it without a done pulse.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    logic [1:0]       mode_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] q_reg;
    logic             sout_reg;
    logic             done_reg;

    logic [WIDTH-1:0] q_next;
    logic             sout_next;

    // Step datapath always works on the latched mode so mid-run mode
    // changes on the port have no effect.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q_reg),
        .mode    (mode_reg),
        .sin     (sin),
        .q_next  (q_next),
        .out_bit (sout_next)
    );

    // Controller, step counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_SHL;
            cnt_reg   <= '0;
            q_reg     <= '0;
            sout_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        // load has priority over a simultaneous start
                        q_reg <= d;
                    end else if (start) begin
                        if (amount == '0) begin
                            // nothing to do: acknowledge immediately
                            done_reg <= 1'b1;
                        end else begin
                            mode_reg  <= mode;
                            cnt_reg   <= amount;
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (load) begin
                        // abort: take new data, drop the run silently
                        q_reg     <= d;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        q_reg    <= q_next;
                        sout_reg <= sout_next;
                        cnt_reg  <= cnt_reg - AMT_W'(1);
                        if (cnt_reg == AMT_W'(1)) begin
                            state_reg <= ST_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign q    = q_reg;
    assign sout = sout_reg;
    assign busy = (state_reg == ST_SHIFT);
    assign done = done_reg;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register and the next generation of the team's 4-bit load/shift register. It provides synchronous parallel load plus a self-timed multi-step operation: on start it performs `amount` single-bit shift or rotate steps, one per clock, then pulses done. It is intended as a serialiser/deserialiser and bit-manipulation building block in datapath exercises.

Parameters:
WIDTH, 8, register width in bits; must be >= 2.
AMT_W, $clog2(WIDTH)+1, width of the amount port; derived, must not be overridden.

Ports:
clk     input   1       system clock, rising edge
rst     input   1       asynchronous reset, active-high
load    input   1       parallel load of d into q
d       input   WIDTH   parallel load data
start   input   1       begin a multi-step operation (pulse, sampled at rising edge)
mode    input   2       operation: 00 SHL, 01 SHR, 10 ROL, 11 ROR
amount  input   AMT_W   number of single-bit steps to perform
sin     input   1       serial fill bit for SHL/SHR
q       output  WIDTH   register contents
sout    output  1       last bit shifted or rotated out
busy    output  1       high while an operation is in progress
done    output  1       one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-high) forces q=0, sout=0, busy=0, done=0, state IDLE, step counter 0. Reset asserted mid-operation aborts the operation immediately, and no done pulse follows.
- State machine states: IDLE and SHIFT. busy is high exactly when state is SHIFT.
- done defaults to 0 every cycle. It is high for exactly one cycle, only as described below.
- IDLE with load=1: q <= d. A start in the same cycle is ignored (load wins). sout is unchanged.
- IDLE with start=1, load=0, amount=0: q is unchanged, done=1 in the next cycle, busy stays 0.
- IDLE with start=1, load=0, amount=k>0: at that edge, latch mode, set the counter to k, and go to SHIFT. No shift happens at the start edge.
- SHIFT: each edge performs one step and decrements the counter.
- Completion: on the edge where the counter goes 1->0, the state returns to IDLE, and busy=0 and done=1 in the following cycle. busy is high exactly k cycles. q reflects all k steps in the cycle where done=1.
- Step definitions (W=WIDTH):
  - SHL: q <= {q[W-2:0], sin}, sout <= q[W-1]
  - SHR: q <= {sin, q[W-1:1]}, sout <= q[0]
  - ROL: q <= {q[W-2:0], q[W-1]}, sout <= q[W-1]
  - ROR: q <= {q[0], q[W-1:1]}, sout <= q[0]
- Inputs during an operation:
  - mode is latched at start; changes while busy are ignored.
  - sin is sampled at every step edge.
  - amount is not clamped: amount >= WIDTH with SHL/SHR fills the whole register with sin values, and with ROL/ROR it wraps normally.
  - start while busy is ignored.
  - load while busy aborts: q <= d, state returns to IDLE, busy=0 next cycle, no done pulse, sout unchanged.

Decomposition:
- Shared package shift_pkg holds:
  - mode constants MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_ROL=2'b10, MODE_ROR=2'b11;
  - state encoding ST_IDLE=1'b0, ST_SHIFT=1'b1.
- One natural sub-module, shift_step: combinational, parametrised by WIDTH. Inputs are q, mode and sin; outputs are the next q and the out bit. It is instantiated once by univ_shift_reg, which holds the FSM, counter and registers.

Test Plan:
- Reset: rst pulsed high during a busy ROL with amount=5 -> q=8'h00, busy=0, done=0 immediately, and no later done pulse.
- Rotate: load d=8'hA5, then start ROL amount=3 -> q steps 4B, 96, 2D; busy high 3 cycles; done pulses once with q=8'h2D, sout=1.
- Shift right fill: load 8'h0F, sin=1, start SHR amount=4 -> q steps 87, C3, E1, F0; final sout=1; done pulses once.
- Full shift-out: load 8'hFF, sin=0, start SHL amount=8 -> q=8'h00 at done; busy high exactly 8 cycles; final sout=1.
- Abort: load 8'h01, start ROR amount=5; after the first step (q=8'h80), assert load with d=8'h3C -> q=8'h3C, busy=0 next cycle, done never asserted.
- Corners:
  - start with amount=0 -> done pulses next cycle, busy stays 0, q unchanged.
  - load and start in the same IDLE cycle -> q=d, busy stays 0, no done.
  - start while busy -> no effect.
